// File: rtl/acc_mac_sequencer.sv
// N-tap signed multiply-accumulate sequencer feeding one accumulator-bank entry.
// Define ACC_MAC_SATURATE_EN for saturating accumulation (default: wrap-around).
module acc_mac_sequencer #(
   parameter int unsigned DATA_W    = 32,
   parameter int unsigned ADDR_W    = 8,
   parameter int unsigned ACC_SEL_W = 5
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 start,
   input  logic [ADDR_W-1:0]    tap_count,
   input  logic [ADDR_W-1:0]    coef_base,
   input  logic [ADDR_W-1:0]    sample_base,
   input  logic [ACC_SEL_W-1:0] acc_sel,
   output logic                 mem_rd_en,
   output logic [ADDR_W-1:0]    coef_addr,
   output logic [ADDR_W-1:0]    sample_addr,
   input  logic [DATA_W-1:0]    coef_data,
   input  logic [DATA_W-1:0]    sample_data,
   output logic                 acc_wr_en,
   output logic [ACC_SEL_W-1:0] acc_wr_sel,
   output logic [DATA_W-1:0]    acc_wr_data,
   output logic                 busy,
   output logic                 done
);

   typedef enum logic [1:0] {StIdle, StIssue, StDrain, StWrite} state_e;

   localparam logic [ADDR_W-1:0] AddrOne = ADDR_W'(1);

   state_e                 state_q, state_d;
   logic [ADDR_W-1:0]      n_q, n_d;
   logic [ADDR_W-1:0]      coef_base_q, coef_base_d;
   logic [ADDR_W-1:0]      sample_base_q, sample_base_d;
   logic [ACC_SEL_W-1:0]   sel_q, sel_d;
   logic [ADDR_W-1:0]      idx_q, idx_d;
   logic [ADDR_W-1:0]      idx_nxt;
   logic [DATA_W-1:0]      sum_q, sum_d;
   logic                   rd_pend_q;
   logic [DATA_W-1:0]      prod;
   logic [DATA_W-1:0]      sum_acc;

   logic                   mem_rd_en_d, acc_wr_en_d, busy_d, done_d;
   logic [ADDR_W-1:0]      coef_addr_d, sample_addr_d;
   logic [ACC_SEL_W-1:0]   acc_wr_sel_d;
   logic [DATA_W-1:0]      acc_wr_data_d;

   // Low DATA_W bits of a signed product equal those of the unsigned product.
   assign prod = coef_data * sample_data;

`ifdef ACC_MAC_SATURATE_EN
   logic [DATA_W:0] sum_wide;
   assign sum_wide = {sum_q[DATA_W-1], sum_q} + {prod[DATA_W-1], prod};
   assign sum_acc  = (sum_wide[DATA_W] != sum_wide[DATA_W-1]) ?
                     {sum_wide[DATA_W], {(DATA_W-1){~sum_wide[DATA_W]}}} :
                     sum_wide[DATA_W-1:0];
`else
   assign sum_acc = sum_q + prod;
`endif

   assign idx_nxt = idx_q + AddrOne;

   always_comb begin
      state_d       = state_q;
      n_d           = n_q;
      coef_base_d   = coef_base_q;
      sample_base_d = sample_base_q;
      sel_d         = sel_q;
      idx_d         = idx_q;
      // Read data arrives the cycle after each strobe.
      sum_d         = rd_pend_q ? sum_acc : sum_q;
      mem_rd_en_d   = 1'b0;
      coef_addr_d   = '0;
      sample_addr_d = '0;
      acc_wr_en_d   = 1'b0;
      done_d        = 1'b0;
      acc_wr_sel_d  = '0;
      acc_wr_data_d = '0;

      unique case (state_q)
         StIdle: begin
            if (start) begin
               n_d           = tap_count;
               coef_base_d   = coef_base;
               sample_base_d = sample_base;
               sel_d         = acc_sel;
               idx_d         = '0;
               sum_d         = '0;
               if (tap_count != '0) begin
                  state_d       = StIssue;
                  mem_rd_en_d   = 1'b1;
                  coef_addr_d   = coef_base;
                  sample_addr_d = sample_base;
               end else begin
                  state_d      = StWrite;
                  acc_wr_en_d  = 1'b1;
                  done_d       = 1'b1;
                  acc_wr_sel_d = acc_sel;
               end
            end
         end
         StIssue: begin
            if (idx_q == n_q - AddrOne) begin
               state_d = StDrain;
            end else begin
               idx_d         = idx_nxt;
               mem_rd_en_d   = 1'b1;
               coef_addr_d   = coef_base_q + idx_nxt;
               sample_addr_d = sample_base_q + idx_nxt;
            end
         end
         StDrain: begin
            state_d       = StWrite;
            acc_wr_en_d   = 1'b1;
            done_d        = 1'b1;
            acc_wr_sel_d  = sel_q;
            acc_wr_data_d = sum_d;
         end
         StWrite: begin
            state_d = StIdle;
         end
         default: state_d = StIdle;
      endcase

      busy_d = (state_d != StIdle);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q       <= StIdle;
         n_q           <= '0;
         coef_base_q   <= '0;
         sample_base_q <= '0;
         sel_q         <= '0;
         idx_q         <= '0;
         sum_q         <= '0;
         rd_pend_q     <= 1'b0;
         mem_rd_en     <= 1'b0;
         coef_addr     <= '0;
         sample_addr   <= '0;
         acc_wr_en     <= 1'b0;
         acc_wr_sel    <= '0;
         acc_wr_data   <= '0;
         busy          <= 1'b0;
         done          <= 1'b0;
      end else begin
         state_q       <= state_d;
         n_q           <= n_d;
         coef_base_q   <= coef_base_d;
         sample_base_q <= sample_base_d;
         sel_q         <= sel_d;
         idx_q         <= idx_d;
         sum_q         <= sum_d;
         rd_pend_q     <= mem_rd_en;
         mem_rd_en     <= mem_rd_en_d;
         coef_addr     <= coef_addr_d;
         sample_addr   <= sample_addr_d;
         acc_wr_en     <= acc_wr_en_d;
         acc_wr_sel    <= acc_wr_sel_d;
         acc_wr_data   <= acc_wr_data_d;
         busy          <= busy_d;
         done          <= done_d;
      end
   end

endmodule

// File: tb/tb_acc_mac_sequencer.sv
// Directed bench for acc_mac_sequencer with a one-cycle-latency data memory model.
module tb_acc_mac_sequencer;

   localparam int DW = 32;
   localparam int AW = 8;
   localparam int SW = 5;

   logic          clk = 1'b0;
   logic          reset;
   logic          start;
   logic [AW-1:0] tap_count, coef_base, sample_base;
   logic [SW-1:0] acc_sel;
   logic          mem_rd_en;
   logic [AW-1:0] coef_addr, sample_addr;
   logic [DW-1:0] coef_data = '0;
   logic [DW-1:0] sample_data = '0;
   logic          acc_wr_en;
   logic [SW-1:0] acc_wr_sel;
   logic [DW-1:0] acc_wr_data;
   logic          busy, done;

   logic [DW-1:0] coef_mem   [256];
   logic [DW-1:0] sample_mem [256];

   int n_checks = 0;
   int n_pass   = 0;

   acc_mac_sequencer dut (
      .clk         (clk),
      .reset       (reset),
      .start       (start),
      .tap_count   (tap_count),
      .coef_base   (coef_base),
      .sample_base (sample_base),
      .acc_sel     (acc_sel),
      .mem_rd_en   (mem_rd_en),
      .coef_addr   (coef_addr),
      .sample_addr (sample_addr),
      .coef_data   (coef_data),
      .sample_data (sample_data),
      .acc_wr_en   (acc_wr_en),
      .acc_wr_sel  (acc_wr_sel),
      .acc_wr_data (acc_wr_data),
      .busy        (busy),
      .done        (done)
   );

   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (mem_rd_en) begin
         coef_data   <= coef_mem[coef_addr];
         sample_data <= sample_mem[sample_addr];
      end
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs === exp) n_pass++;
      else $display("FAIL %s: got 0x%08h, want 0x%08h", tag, obs, exp);
   endtask

   task automatic clear_mem();
      for (int i = 0; i < 256; i++) begin
         coef_mem[i]   = '0;
         sample_mem[i] = '0;
      end
   endtask

   // One operation; cycle k is observed at the falling edge after start-sampling edge k-1.
   task automatic run_op(input string tag, input logic [AW-1:0] n, input logic [AW-1:0] cb,
                         input logic [AW-1:0] sb, input logic [SW-1:0] sel,
                         input logic [DW-1:0] exp_sum, input int restart_cyc);
      int            wcyc, rd_cnt, last_rd, addr_err, wr_cnt, wr_at, done_cnt, done_at;
      int            busy_cnt;
      logic          busy_after;
      logic [DW-1:0] wr_data;
      logic [SW-1:0] wr_sel;
      logic [AW-1:0] off;
      wcyc = (n == 0) ? 1 : int'(n) + 2;
      rd_cnt = 0; last_rd = 0; addr_err = 0; wr_cnt = 0; wr_at = 0;
      done_cnt = 0; done_at = 0; busy_cnt = 0; busy_after = 1'b1;
      wr_data = '0; wr_sel = '0;
      @(negedge clk);
      tap_count = n; coef_base = cb; sample_base = sb; acc_sel = sel; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      for (int k = 1; k <= wcyc + 4; k++) begin
         if (mem_rd_en) begin
            rd_cnt++;
            last_rd = k;
            off = AW'(k - 1);
            if (coef_addr !== AW'(cb + off) || sample_addr !== AW'(sb + off)) addr_err++;
         end
         if (acc_wr_en) begin
            wr_cnt++;
            wr_at   = k;
            wr_data = acc_wr_data;
            wr_sel  = acc_wr_sel;
         end
         if (done) begin
            done_cnt++;
            done_at = k;
         end
         if (busy) busy_cnt++;
         if (k == wcyc + 1) busy_after = busy;
         if (k == restart_cyc) begin
            start = 1'b1; tap_count = 8'd1; coef_base = 8'h00; sample_base = 8'h00;
            acc_sel = 5'd3;
         end else begin
            start = 1'b0;
         end
         @(negedge clk);
      end
      check({tag, ".rd_cnt"},     32'(rd_cnt),     32'(n));
      check({tag, ".last_rd"},    32'(last_rd),    32'(n));
      check({tag, ".addr_err"},   32'(addr_err),   32'd0);
      check({tag, ".wr_cnt"},     32'(wr_cnt),     32'd1);
      check({tag, ".wr_cycle"},   32'(wr_at),      32'(wcyc));
      check({tag, ".wr_data"},    wr_data,         exp_sum);
      check({tag, ".wr_sel"},     32'(wr_sel),     32'(sel));
      check({tag, ".done_cnt"},   32'(done_cnt),   32'd1);
      check({tag, ".done_cycle"}, 32'(done_at),    32'(wcyc));
      check({tag, ".busy_cnt"},   32'(busy_cnt),   32'(wcyc));
      check({tag, ".busy_after"}, 32'(busy_after), 32'd0);
   endtask

   initial begin
      int            wr_seen;
      logic [DW-1:0] exp_ovf;
      reset = 1'b1; start = 1'b0;
      tap_count = '0; coef_base = '0; sample_base = '0; acc_sel = '0;
      clear_mem();
      repeat (3) @(negedge clk);
      check("rst0.busy",      32'(busy),        32'd0);
      check("rst0.done",      32'(done),        32'd0);
      check("rst0.mem_rd_en", 32'(mem_rd_en),   32'd0);
      check("rst0.acc_wr_en", 32'(acc_wr_en),   32'd0);
      check("rst0.wr_data",   acc_wr_data,      32'd0);
      reset = 1'b0;

      // 1*4 + 2*5 + 3*6 = 32
      coef_mem[8'h10] = 32'd1; coef_mem[8'h11] = 32'd2; coef_mem[8'h12] = 32'd3;
      sample_mem[8'h20] = 32'd4; sample_mem[8'h21] = 32'd5; sample_mem[8'h22] = 32'd6;
      run_op("n3", 8'd3, 8'h10, 8'h20, 5'd9, 32'h0000_0020, -1);

      run_op("n0", 8'd0, 8'h33, 8'h44, 5'd8, 32'h0000_0000, -1);

      // -2*3 + 5*1 = -1, sample address wraps 0xFF -> 0x00
      coef_mem[8'h40] = 32'hFFFF_FFFE; coef_mem[8'h41] = 32'd5;
      sample_mem[8'hFF] = 32'd3; sample_mem[8'h00] = 32'd1;
      run_op("wrap", 8'd2, 8'h40, 8'hFF, 5'd17, 32'hFFFF_FFFF, -1);

`ifdef ACC_MAC_SATURATE_EN
      exp_ovf = 32'h7FFF_FFFF;
`else
      exp_ovf = 32'h8000_0000;
`endif
      coef_mem[8'h50] = 32'h7FFF_FFFF; coef_mem[8'h51] = 32'd1;
      sample_mem[8'h60] = 32'd1; sample_mem[8'h61] = 32'd1;
      run_op("ovf", 8'd2, 8'h50, 8'h60, 5'd31, exp_ovf, -1);

      // 1*7 + (-1)*2 + 2*(-4) + 3*10 = 27; a second start in cycle 2 must be ignored
      coef_mem[8'h80] = 32'd1; coef_mem[8'h81] = 32'hFFFF_FFFF;
      coef_mem[8'h82] = 32'd2; coef_mem[8'h83] = 32'd3;
      sample_mem[8'h90] = 32'd7; sample_mem[8'h91] = 32'd2;
      sample_mem[8'h92] = 32'hFFFF_FFFC; sample_mem[8'h93] = 32'd10;
      run_op("ign", 8'd4, 8'h80, 8'h90, 5'd12, 32'h0000_001B, 2);

      // Reset in cycle 3 of an N=4 run.
      @(negedge clk);
      tap_count = 8'd4; coef_base = 8'h80; sample_base = 8'h90; acc_sel = 5'd5;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      @(negedge clk);
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      check("rstmid.mem_rd_en",   32'(mem_rd_en),   32'd0);
      check("rstmid.coef_addr",   32'(coef_addr),   32'd0);
      check("rstmid.sample_addr", 32'(sample_addr), 32'd0);
      check("rstmid.busy",        32'(busy),        32'd0);
      check("rstmid.done",        32'(done),        32'd0);
      check("rstmid.acc_wr_en",   32'(acc_wr_en),   32'd0);
      check("rstmid.acc_wr_sel",  32'(acc_wr_sel),  32'd0);
      check("rstmid.acc_wr_data", acc_wr_data,      32'd0);
      reset = 1'b0;
      wr_seen = 0;
      for (int k = 0; k < 8; k++) begin
         if (acc_wr_en) wr_seen++;
         @(negedge clk);
      end
      check("rstmid.no_write", 32'(wr_seen), 32'd0);
      run_op("after_rst", 8'd4, 8'h80, 8'h90, 5'd5, 32'h0000_001B, -1);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: got running, want finished");
      $fatal(1);
   end

endmodule
